// File: rtl/call_request_latch_if.sv
// rtl/call_request_latch_if.sv - button/sensor/controller bundle for call_request_latch
//
// Inputs to the latch (driven by the master side):
//   F[4:0]   cabin buttons, bit0 = floor 1
//   U[3:0]   hall up buttons, bit0 = U1 .. bit3 = U4
//   D[3:0]   hall down buttons, bit0 = D2 .. bit3 = D5
//   S[4:0]   one-hot floor sensors, bit0 = floor 1
//   AC[1:0]  motor command: 00 stop, 01 up, 10 down, 11 stop
//   Open     door-open indication
// Outputs from the latch (driven by the slave side):
//   pend_car, pend_up, pend_dn   latched requests, bit i = floor i+1
//   cur_floor                    last valid floor 1..5, 0 = unknown
//   req_here/above/below         pending-request summaries
//   err_sensor                   multi-hot S seen on the previous edge
interface call_request_latch_if;
    logic [4:0] F;
    logic [3:0] U;
    logic [3:0] D;
    logic [4:0] S;
    logic [1:0] AC;
    logic       Open;
    logic [4:0] pend_car;
    logic [4:0] pend_up;
    logic [4:0] pend_dn;
    logic [2:0] cur_floor;
    logic       req_here;
    logic       req_above;
    logic       req_below;
    logic       err_sensor;

    modport master (
        output F, U, D, S, AC, Open,
        input  pend_car, pend_up, pend_dn, cur_floor,
        input  req_here, req_above, req_below, err_sensor
    );

    modport slave (
        input  F, U, D, S, AC, Open,
        output pend_car, pend_up, pend_dn, cur_floor,
        output req_here, req_above, req_below, err_sensor
    );
endinterface

// File: rtl/call_request_latch.sv
// rtl/call_request_latch.sv - debounced elevator call latch with floor tracking and service clear
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   call_request_latch_if.slave: buttons, sensors and controller
//         feedback in; registered request vectors and summaries out
// Parameters:
//   DEB_CYCLES  consecutive high samples before a button latches (1..15)
//   NFLOORS     number of floors (5 in this revision)
module call_request_latch #(
    parameter int DEB_CYCLES = 2,
    parameter int NFLOORS    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    call_request_latch_if.slave  bus
);
    // Buttons are handled as one flat vector: {D5..D2, U4..U1, F5..F1}.
    localparam int         NBTN = 3 * NFLOORS - 2;
    localparam logic [3:0] DEB  = 4'(DEB_CYCLES);

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    dir_t                dir_q, dir_d;
    logic [3:0]          cnt_q   [NBTN];
    logic [3:0]          cnt_inc [NBTN];
    logic [NBTN-1:0]     armed_q;
    logic [NFLOORS-1:0]  car_q, up_q, dn_q;
    logic [NFLOORS-1:0]  car_d, up_d, dn_d;
    logic [2:0]          floor_q, floor_d;
    logic                err_q, err_d;

    logic [NBTN-1:0]     btn;
    logic [NBTN-1:0]     btn_clr;
    logic [NBTN-1:0]     fire;
    logic [NFLOORS-1:0]  clr_car, clr_up, clr_dn;
    logic [NFLOORS-1:0]  pend_all;

    assign btn      = {bus.D, bus.U, bus.F};
    assign pend_all = car_q | up_q | dn_q;

    // Service clear for the floor the car is parked at with the door open.
    // Hall calls in the direction opposite to the remembered travel stay
    // pending, except at the end floors where only one direction exists.
    always_comb begin
        clr_car = '0;
        clr_up  = '0;
        clr_dn  = '0;
        if (bus.Open && floor_q != 3'd0) begin
            for (int i = 0; i < NFLOORS; i++) begin
                if (floor_q == 3'(i + 1)) begin
                    clr_car[i] = 1'b1;
                    clr_up[i]  = (dir_q != DIR_DOWN) || (i == 0);
                    clr_dn[i]  = (dir_q != DIR_UP) || (i == NFLOORS - 1);
                end
            end
        end
    end

    assign btn_clr = {clr_dn[NFLOORS-1:1], clr_up[NFLOORS-2:0], clr_car};

    // A button fires once its run of high samples reaches DEB while armed.
    // A fire suppressed by a clear keeps the button armed, so a still-held
    // press latches as soon as the door closes.
    always_comb begin
        fire = '0;
        for (int b = 0; b < NBTN; b++) begin
            cnt_inc[b] = (cnt_q[b] == 4'hF) ? 4'hF : cnt_q[b] + 4'd1;
            fire[b]    = btn[b] && armed_q[b] && (cnt_inc[b] >= DEB) && !btn_clr[b];
        end
    end

    always_comb begin
        car_d = (car_q | fire[NFLOORS-1:0]) & ~clr_car;
        up_d  = (up_q | {1'b0, fire[2*NFLOORS-2:NFLOORS]}) & ~clr_up;
        dn_d  = (dn_q | {fire[NBTN-1:2*NFLOORS-1], 1'b0}) & ~clr_dn;
        up_d[NFLOORS-1] = 1'b0;
        dn_d[0]         = 1'b0;
    end

    // Floor tracking: only a clean one-hot sample moves the floor.
    always_comb begin
        logic [2:0] hits;
        logic [2:0] enc;
        hits = '0;
        enc  = '0;
        for (int i = 0; i < NFLOORS; i++) begin
            hits = hits + {2'b0, bus.S[i]};
            if (bus.S[i]) enc = 3'(i + 1);
        end
        floor_d = (hits == 3'd1) ? enc : floor_q;
        err_d   = (hits > 3'd1);
    end

    always_comb begin
        dir_d = dir_q;
        if (pend_all == '0) begin
            dir_d = DIR_IDLE;
        end else begin
            case (bus.AC)
                2'b01:   dir_d = DIR_UP;
                2'b10:   dir_d = DIR_DOWN;
                default: dir_d = dir_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q <= DIR_IDLE;
        end else begin
            dir_q <= dir_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            car_q   <= '0;
            up_q    <= '0;
            dn_q    <= '0;
            floor_q <= '0;
            err_q   <= 1'b0;
            armed_q <= '1;
            for (int b = 0; b < NBTN; b++) cnt_q[b] <= '0;
        end else begin
            car_q   <= car_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            floor_q <= floor_d;
            err_q   <= err_d;
            for (int b = 0; b < NBTN; b++) begin
                if (btn[b]) begin
                    cnt_q[b] <= cnt_inc[b];
                    if (fire[b]) armed_q[b] <= 1'b0;
                end else begin
                    cnt_q[b]   <= '0;
                    armed_q[b] <= 1'b1;
                end
            end
        end
    end

    // Summaries relative to the current floor; unknown floor reports
    // everything as "above" so the controller starts moving.
    always_comb begin
        bus.req_here  = 1'b0;
        bus.req_above = 1'b0;
        bus.req_below = 1'b0;
        if (floor_q == 3'd0) begin
            bus.req_above = |pend_all;
        end else begin
            for (int i = 0; i < NFLOORS; i++) begin
                if (3'(i + 1) == floor_q)     bus.req_here  = bus.req_here  | pend_all[i];
                else if (3'(i + 1) > floor_q) bus.req_above = bus.req_above | pend_all[i];
                else                          bus.req_below = bus.req_below | pend_all[i];
            end
        end
    end

    assign bus.pend_car   = car_q;
    assign bus.pend_up    = up_q;
    assign bus.pend_dn    = dn_q;
    assign bus.cur_floor  = floor_q;
    assign bus.err_sensor = err_q;
endmodule

// File: doc/call_request_latch.md
Name: call_request_latch

Overview:
- Upstream front end of the elevator controller.
- Debounces and latches cabin (F1..F5) and hall (U1..U4, D2..D5) buttons into pending-request registers, and tracks the current floor from the one-hot sensors S1..S5.
- Clears each request when the controller serves it, using the controller's AC and Open feedback.
- Gives the controller registered request vectors plus above/below/here summaries, so it does not consume raw button levels.

Parameters:
- DEB_CYCLES, 2, consecutive high samples needed before a button latches (legal range 1..15).
- NFLOORS, 5, number of floors; fixed at 5 in this revision.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- F  input  5  cabin buttons; bit0 = floor 1.
- U  input  4  hall up buttons; bit0 = U1 .. bit3 = U4.
- D  input  4  hall down buttons; bit0 = D2 .. bit3 = D5.
- S  input  5  floor sensors, one-hot; bit0 = floor 1.
- AC  input  2  controller motor command: 00 stop, 01 up, 10 down, 11 treated as stop.
- Open  input  1  controller door-open indication.
- pend_car  output  5  latched cabin requests.
- pend_up  output  5  latched up calls; bit4 is always 0.
- pend_dn  output  5  latched down calls; bit0 is always 0.
- cur_floor  output  3  last valid floor, 1..5; 0 = unknown.
- req_here  output  1  any pending request at cur_floor.
- req_above  output  1  any pending request above cur_floor.
- req_below  output  1  any pending request below cur_floor.
- err_sensor  output  1  more than one S bit was high on the previous edge.

Behaviour:
- Reset (rst=0, asynchronous): all pend_* = 0, cur_floor = 0, err_sensor = 0, every debounce counter = 0, last_dir = IDLE, every re-arm flag set.
- Debounce: one saturating counter per button (13 total).
  - Input high: counter increments. Input low: counter clears and re-arm is set.
  - When the counter reaches DEB_CYCLES with re-arm set, the pend bit sets on that edge and re-arm clears.
  - A press held for exactly DEB_CYCLES edges is visible after the DEB_CYCLES-th edge.
  - Holding a button never re-latches; the button must go low first.
- Floor tracking:
  - S exactly one-hot: cur_floor <= encoded floor (1..5).
  - S = 0: cur_floor holds.
  - S multi-hot: cur_floor holds and err_sensor = 1 for that cycle (registered); otherwise err_sensor = 0.
- Direction memory: AC = 01 sets last_dir = UP; AC = 10 sets last_dir = DOWN. Stop holds last_dir. last_dir returns to IDLE when no pend bit is set.
- Service clear: active only when Open = 1 and cur_floor = k (k ≠ 0), registered on the next edge.
  - pend_car[k] always clears.
  - pend_up[k] clears if last_dir ≠ DOWN, or if k = 1.
  - pend_dn[k] clears if last_dir ≠ UP, or if k = 5.
- Simultaneous events:
  - Clear wins over a latch to the same bit on the same edge.
  - Presses at floor k are ignored while the clear condition for that bit is active; the counter still runs, and the bit latches after Open falls if the button is still held and re-armed.
  - Presses at other floors latch normally during a clear.
- Summaries: combinational from registered state. P = pend_car | pend_up | pend_dn.
  - req_here = P[cur_floor-1].
  - req_above = OR of P above cur_floor.
  - req_below = OR of P below cur_floor.
  - When cur_floor = 0: req_above = |P, req_here = 0, req_below = 0.
- Reset mid-operation: every pending request is dropped immediately; nothing is retained.
- No combinational path from any button input to any output.

Test Plan:
- Reset, then S = 00001 for 1 cycle → cur_floor = 1, all pend = 0, req_* = 0. Repeat with rst pulsed low mid-cycle → outputs zero without waiting for a clock edge.
- DEB_CYCLES = 2, D[3] (D5) high for 1 cycle → pend_dn = 0. D[3] high for 2 cycles → pend_dn = 10000 after the 2nd edge; req_above = 1 with cur_floor = 1.
- F[2] held 10 cycles; Open = 1 at cur_floor = 3 clears pend_car[2]; button still held → bit stays 0 until F[2] drops and is re-pressed for 2 cycles.
- Direction-aware clear: last_dir = DOWN, pend_up[1] = pend_dn[1] = 1, cur_floor = 2, Open = 1 → pend_dn = 0 at bit1, pend_up[1] stays 1.
- S = 00110 → err_sensor = 1 next cycle, cur_floor unchanged (e.g. stays 2). Then S = 01000 → cur_floor = 4, err_sensor = 0.
- Clear-vs-press collision: Open = 1 at floor 3 while F[2] completes debounce on the same edge and U[0] latches → pend_car[2] = 0, pend_up[0] = 1, req_below = 1.
